// File: rtl/kbd_spi_pkg.sv
// kbd_spi_pkg: shared types and constants for the
// keyboard/joystick SPI receiver.
package kbd_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      DISCARD
   } state_t;

   localparam logic [7:0] CMD_MATRIX_DEF = 8'h01;
   localparam logic [7:0] CMD_JOY_DEF    = 8'h02;

   localparam int MATRIX_BITS = 40;
   localparam int JOY_BITS    = 8;
   localparam int ROW_BITS    = 5;
   localparam int NUM_ROWS    = 8;
   localparam int CNT_W       = 6;

endpackage

// File: rtl/kbd_spi_sync.sv
// kbd_spi_sync: synchronizer for one async pin plus
// registered rise/fall pulses, muted until the chain holds real samples.
module kbd_spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic [STAGES:0]   r_vld;
   logic              r_prev;
   logic              r_rise;
   logic              r_fall;

   // Shift the pin in, track the previous level and emit edge pulses.
   // r_vld blocks a false edge from the reset value against a pin
   // that is already at the opposite level when reset is released.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {STAGES{RST_VAL}};
         r_vld  <= '0;
         r_prev <= RST_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_vld  <= {r_vld[STAGES-1:0], 1'b1};
         r_prev <= r_sync[STAGES-1];
         r_rise <= r_vld[STAGES] & r_sync[STAGES-1] & ~r_prev;
         r_fall <= r_vld[STAGES] & ~r_sync[STAGES-1] & r_prev;
      end
   end

   assign o_level = r_prev;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/kbd_spi_rx.sv
// kbd_spi_rx: SPI slave that receives ZX key matrix and
// Kempston joystick frames and serves them to the port read paths.
module kbd_spi_rx
   import kbd_spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CMD_MATRIX  = CMD_MATRIX_DEF,
   parameter logic [7:0] CMD_JOY     = CMD_JOY_DEF
) (
   input  logic                CLK_14MHZ,
   input  logic                CPU_RESET,
   input  logic                KBD_CLK,
   input  logic                KBD_CS,
   input  logic                KBD_DI,
   input  logic [7:0]          A_HI,
   output logic [ROW_BITS-1:0] KBD_ROWS,
   output logic [JOY_BITS-1:0] JOY,
   output logic                FRAME_OK,
   output logic                FRAME_ERR
);

   localparam logic [CNT_W-1:0] EXP_MATRIX = CNT_W'(MATRIX_BITS);
   localparam logic [CNT_W-1:0] EXP_JOY    = CNT_W'(JOY_BITS);

   logic w_sck_rise, w_sck_fall, w_sck_lvl;
   logic w_cs_rise, w_cs_fall, w_cs_lvl;
   logic w_di, w_di_rise, w_di_fall;
   logic w_unused;
   logic w_bit;

   state_t                 r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0]       r_expect, w_expect_nxt;
   logic                   r_is_joy, w_is_joy_nxt;
   logic [MATRIX_BITS-1:0] r_shift, w_shift_nxt;
   logic [MATRIX_BITS-1:0] r_matrix;
   logic [JOY_BITS-1:0]    r_joy;
   logic                   r_ok, r_err;
   logic                   w_commit, w_err;
   logic [7:0]             w_byte;
   logic [ROW_BITS-1:0]    w_rows;

   kbd_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .i_clk   (CLK_14MHZ),
      .i_rst_n (CPU_RESET),
      .i_async (KBD_CLK),
      .o_level (w_sck_lvl),
      .o_rise  (w_sck_rise),
      .o_fall  (w_sck_fall)
   );

   kbd_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .i_clk   (CLK_14MHZ),
      .i_rst_n (CPU_RESET),
      .i_async (KBD_CS),
      .o_level (w_cs_lvl),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   kbd_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_di (
      .i_clk   (CLK_14MHZ),
      .i_rst_n (CPU_RESET),
      .i_async (KBD_DI),
      .o_level (w_di),
      .o_rise  (w_di_rise),
      .o_fall  (w_di_fall)
   );

   assign w_unused = &{w_sck_lvl, w_sck_fall, w_di_rise, w_di_fall};
   assign w_bit    = w_sck_rise & ~w_cs_lvl;
   assign w_byte   = {r_shift[6:0], w_di};

   // State, bit counter and shadow register.
   always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
      if (!CPU_RESET) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_expect <= '0;
         r_is_joy <= 1'b0;
         r_shift  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_expect <= w_expect_nxt;
         r_is_joy <= w_is_joy_nxt;
         r_shift  <= w_shift_nxt;
      end
   end

   // Frame sequencing: CS edges frame the transfer, SCK rises
   // shift bits; a CS rise decides between commit and discard.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_expect_nxt = r_expect;
      w_is_joy_nxt = r_is_joy;
      w_shift_nxt  = r_shift;
      w_commit     = 1'b0;
      w_err        = 1'b0;
      if (w_cs_rise) begin
         w_state_nxt = IDLE;
         if (r_state == DATA && r_cnt == r_expect) begin
            w_commit = 1'b1;
         end else if (r_state != IDLE) begin
            w_err = 1'b1;
         end
      end else if (w_cs_fall && r_state == IDLE) begin
         w_state_nxt = CMD;
         w_cnt_nxt   = '0;
         w_shift_nxt = '0;
      end else if (w_bit) begin
         unique case (r_state)
            CMD: begin
               w_shift_nxt = {r_shift[MATRIX_BITS-2:0], w_di};
               w_cnt_nxt   = r_cnt + 1'b1;
               if (r_cnt == CNT_W'(7)) begin
                  w_cnt_nxt = '0;
                  if (w_byte == CMD_MATRIX) begin
                     w_expect_nxt = EXP_MATRIX;
                     w_is_joy_nxt = 1'b0;
                     w_state_nxt  = DATA;
                  end else if (w_byte == CMD_JOY) begin
                     w_expect_nxt = EXP_JOY;
                     w_is_joy_nxt = 1'b1;
                     w_state_nxt  = DATA;
                  end else begin
                     w_state_nxt = DISCARD;
                  end
               end
            end
            DATA: begin
               w_shift_nxt = {r_shift[MATRIX_BITS-2:0], w_di};
               w_cnt_nxt   = r_cnt + 1'b1;
               if (r_cnt == r_expect) begin
                  w_state_nxt = DISCARD;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Committed matrix/joystick state and the result pulses.
   always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
      if (!CPU_RESET) begin
         r_matrix <= '1;
         r_joy    <= '0;
         r_ok     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ok  <= w_commit;
         r_err <= w_err;
         if (w_commit && !r_is_joy) begin
            r_matrix <= r_shift;
         end
         if (w_commit && r_is_joy) begin
            r_joy <= r_shift[JOY_BITS-1:0];
         end
      end
   end

   // Half-row read mux: AND of every selected (low) row.
   always_comb begin
      w_rows = '1;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (!A_HI[r]) begin
            w_rows = w_rows & r_matrix[r*ROW_BITS +: ROW_BITS];
         end
      end
   end

   assign KBD_ROWS  = w_rows;
   assign JOY       = r_joy;
   assign FRAME_OK  = r_ok;
   assign FRAME_ERR = r_err;

endmodule

// File: tb/tb_kbd_spi_rx.sv
// tb_kbd_spi_rx: directed and random frames against a
// frame-level model of the key matrix and joystick byte.
module tb_kbd_spi_rx;

   localparam int SS = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sck   = 1'b0;
   logic       cs    = 1'b1;
   logic       di    = 1'b1;
   logic [7:0] a_hi  = 8'h00;
   logic [4:0] rows;
   logic [7:0] joy;
   logic       f_ok;
   logic       f_err;

   int total = 0;
   int bad   = 0;

   logic [39:0] m_exp = '1;
   logic [7:0]  j_exp = 8'h00;
   bit          tx_q[$];

   kbd_spi_rx #(.SYNC_STAGES(SS)) dut (
      .CLK_14MHZ (clk),
      .CPU_RESET (rst_n),
      .KBD_CLK   (sck),
      .KBD_CS    (cs),
      .KBD_DI    (di),
      .A_HI      (a_hi),
      .KBD_ROWS  (rows),
      .JOY       (joy),
      .FRAME_OK  (f_ok),
      .FRAME_ERR (f_err)
   );

   always #35 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [39:0] obs,
                      input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_val(input logic [39:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
   endtask

   function automatic logic [4:0] rows_model(input logic [7:0] a);
      logic [4:0] acc;
      acc = 5'h1F;
      for (int r = 0; r < 8; r++)
         if (a[r] == 1'b0) acc = acc & m_exp[r*5 +: 5];
      return acc;
   endfunction

   task automatic check_out();
      logic [7:0] sel [4];
      sel[0] = 8'hFE;
      sel[1] = 8'h7F;
      sel[2] = 8'($urandom);
      sel[3] = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         a_hi = sel[i];
         #1;
         chk($sformatf("rows_a%02h", sel[i]),
             40'(rows), 40'(rows_model(sel[i])));
      end
      chk("joy", 40'(joy), 40'(j_exp));
   endtask

   // Sends tx_q as one CS frame; rst_at >= 0 pulses reset before
   // that bit index while CS stays low.
   task automatic send_frame(input int rst_at);
      int          n;
      logic [7:0]  cmd;
      logic [39:0] pay;
      bit          ok;
      bit          er;
      int          okc, errc, both, lat;
      n   = tx_q.size();
      cmd = 8'h00;
      pay = '0;
      if (n >= 8)
         for (int i = 0; i < 8; i++) cmd = {cmd[6:0], tx_q[i]};
      for (int i = 8; i < n; i++) pay = {pay[38:0], tx_q[i]};
      ok = (rst_at < 0) &&
           ((cmd == 8'h01 && n == 48) || (cmd == 8'h02 && n == 16));
      er = (rst_at < 0) && !ok;
      cs = 1'b0;
      cyc(7);
      for (int i = 0; i < n; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            cyc(4);
            rst_n = 1'b1;
            cyc(3);
         end
         di = tx_q[i];
         cyc(7);
         sck = 1'b1;
         cyc(7);
         sck = 1'b0;
      end
      cyc(7);
      cs = 1'b1;
      okc  = 0;
      errc = 0;
      both = 0;
      lat  = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (f_ok) begin
            okc++;
            if (lat == 0) lat = k;
         end
         if (f_err) errc++;
         if (f_ok && f_err) both++;
      end
      chk("ok_pulses", 40'(okc), ok ? 40'd1 : 40'd0);
      chk("err_pulses", 40'(errc), er ? 40'd1 : 40'd0);
      chk("ok_err_both", 40'(both), 40'd0);
      if (ok) chk("ok_latency", 40'(lat), 40'(SS + 2));
      if (rst_at >= 0) begin
         m_exp = '1;
         j_exp = 8'h00;
      end else if (ok && cmd == 8'h01) begin
         m_exp = pay;
      end else if (ok) begin
         j_exp = pay[7:0];
      end
      tx_q.delete();
      cyc(6);
      check_out();
   endtask

   initial begin
      int          kind;
      int          len;
      logic [39:0] v;

      cyc(3);
      a_hi = 8'h00;
      #1;
      chk("rst_rows", 40'(rows), 40'h1F);
      chk("rst_joy", 40'(joy), 40'h00);
      chk("rst_ok", 40'(f_ok), 40'h0);
      chk("rst_err", 40'(f_err), 40'h0);
      rst_n = 1'b1;
      cyc(6);

      push_val(40'h01, 8);
      push_val(40'hFF_FFFF_FFFE, 40);
      send_frame(-1);
      a_hi = 8'hFE;
      #1;
      chk("mx_row0", 40'(rows), 40'h1E);
      a_hi = 8'h7F;
      #1;
      chk("mx_row7", 40'(rows), 40'h1F);

      push_val(40'h02, 8);
      push_val(40'hA5, 8);
      send_frame(-1);
      chk("joy_a5", 40'(joy), 40'hA5);

      push_val(40'h02, 8);
      push_val(40'h3C, 7);
      send_frame(-1);

      push_val(40'h02, 8);
      push_val(40'h5AC3, 16);
      send_frame(-1);

      push_val(40'h55, 8);
      push_val(40'h00, 8);
      send_frame(-1);

      push_val(40'h0, 4);
      send_frame(-1);
      chk("err_joy_kept", 40'(joy), 40'hA5);

      push_val(40'h01, 8);
      push_val(40'h7F_FFFF_FFFE, 40);
      send_frame(-1);
      a_hi = 8'h7E;
      #1;
      chk("multi_row", 40'(rows), 40'h0E);

      push_val(40'h01, 8);
      push_val(40'h00_0000_0000, 40);
      send_frame(28);
      a_hi = 8'h00;
      #1;
      chk("midrst_rows", 40'(rows), 40'h1F);

      push_val(40'h01, 8);
      push_val(40'hFF_FFFF_FFEF, 40);
      send_frame(-1);
      a_hi = 8'hFE;
      #1;
      chk("post_rst_row0", 40'(rows), 40'h0F);

      for (int it = 0; it < 12; it++) begin
         kind = $urandom_range(0, 4);
         v    = {8'($urandom), 32'($urandom)};
         case (kind)
            0: begin
               push_val(40'h01, 8);
               push_val(v, 40);
            end
            1: begin
               push_val(40'h02, 8);
               push_val(v, 8);
            end
            2: begin
               len = $urandom_range(0, 15);
               if (len >= 8) len++;
               push_val(40'h02, 8);
               push_val(v, len);
            end
            3: begin
               push_val(40'($urandom_range(3, 255)), 8);
               push_val(v, 8);
            end
            default: begin
               push_val(40'h01, 8);
               push_val(v, $urandom_range(0, 39));
            end
         endcase
         send_frame(-1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kbd_spi_rx.md
# kbd_spi_rx

SPI slave receiver for the keyboard/joystick link from the USB/PS2/SEGA-GP controller into the CPLD. It deserializes frames arriving on KBD_CLK/KBD_CS/KBD_DI and holds the ZX 8×5 key matrix and a Kempston joystick byte. It presents the selected half-rows to the port #FE read path and the joystick byte to the #1F read path. The block is fully synchronous to CLK_14MHZ; the SPI pins are treated as asynchronous inputs.

## Interface
- SYNC_STAGES, 2, synchronizer depth on KBD_CLK/KBD_CS/KBD_DI (≥2)
- CMD_MATRIX, 8'h01, command byte: 5 data bytes follow (40-bit matrix)
- CMD_JOY, 8'h02, command byte: 1 data byte follows (Kempston)
- CLK_14MHZ  in  1  system clock, all state on rising edge
- CPU_RESET  in  1  asynchronous, active-low reset
- KBD_CLK  in  1  SPI SCK, mode 0, idle low
- KBD_CS  in  1  SPI chip select, active low, frames transfers
- KBD_DI  in  1  SPI MOSI, MSB first
- A_HI  in  8  CPU A[15:8], half-row select (0 = selected)
- KBD_ROWS  out  5  active-low key bits for the selected rows
- JOY  out  8  Kempston byte, active high
- FRAME_OK  out  1  one-cycle pulse on a committed frame
- FRAME_ERR  out  1  one-cycle pulse on a discarded frame

## Operation
- SCK, CS and DI each pass through a SYNC_STAGES flop chain. Edges are detected on the synchronized SCK and CS.
- DI is sampled on a synchronized SCK rising edge while synchronized CS is low. SCK edges while CS is high are ignored.
- The FSM has four states: IDLE, CMD, DATA, DISCARD.
  - IDLE: a CS falling edge moves to CMD and clears the bit counter (6 bits) and the shift register.
  - CMD: after 8 bits, if the command equals CMD_MATRIX, expect 40 data bits; if it equals CMD_JOY, expect 8. Either way, go to DATA. Any other command goes to DISCARD.
  - DATA: shift bits into a 40-bit shadow. When expected+1 bits arrive (overrun), go to DISCARD.
  - DISCARD: ignore bits until CS rises.
- A CS rising edge in any state returns to IDLE.
  - Commit happens only if the state is DATA with exactly the expected count. A matrix frame writes the 40-bit matrix; a joystick frame writes JOY from the low 8 shadow bits. FRAME_OK pulses.
  - Otherwise (short frame, overrun, unknown command, CS rise during CMD), no register changes and FRAME_ERR pulses.
- Matrix layout: bits shift in MSB first into m[39:0]. Row r (r=0..7, selected by A_HI[r]) is m[5r+4:5r], so the last 5 bits received form row 0.
- KBD_ROWS is combinational. Each bit is the AND, over all rows r with A_HI[r]=0, of row r's bit. With no row selected it is 5'b11111.
- Reset values:
  - matrix all ones (no key pressed), so KBD_ROWS = 5'b11111
  - JOY = 8'h00
  - FRAME_OK = FRAME_ERR = 0
  - state IDLE, counter 0
- Reset mid-frame abandons the frame with no pulse. The partially received frame is not committed, even if CS is still low when reset is released.
- Back-to-back frames are legal. A CS fall in the same cycle as commit starts the new frame normally.

## Timing
- Supported SCK: high and low phases each ≥ 3 CLK_14MHZ cycles (≤ ~2.3 MHz). CS setup and hold to the first and last SCK edge must be ≥ 3 cycles.
- Latency from a pin edge to the internal edge pulse is SYNC_STAGES+1 cycles.
- Latency from the CS pin rising edge to an updated KBD_ROWS/JOY and the FRAME_OK pulse is SYNC_STAGES+2 cycles. Both happen in the same cycle.
- KBD_ROWS follows A_HI combinationally with zero cycles latency, so it is valid within the CPU IORQ/RD window.
- FRAME_OK and FRAME_ERR are exactly one cycle wide and never asserted together.

## Structure
- Package kbd_spi_pkg holds:
  - state enum (IDLE, CMD, DATA, DISCARD)
  - default CMD_MATRIX/CMD_JOY values
  - MATRIX_BITS=40, JOY_BITS=8, ROW_BITS=5
- Sub-module kbd_spi_sync handles one async input. It contains a SYNC_STAGES synchronizer plus a rise/fall pulse generator, and is instantiated three times. It is reset to idle levels: SCK 0, CS 1, DI 1.
- The top level contains the FSM, counter, shadow register, matrix/joy registers and the row mux.

## Test plan
- Reset: after CPU_RESET low, A_HI=8'h00 -> KBD_ROWS=5'b11111, JOY=8'h00, no pulses.
- Matrix frame: 01 followed by 40 bits with only row 0 bit 0 low (last byte 8'hFE, others FF), SCK 1 MHz. Then A_HI=8'hFE -> KBD_ROWS=5'b11110, and A_HI=8'h7F -> 5'b11111. FRAME_OK pulses once, SYNC_STAGES+2 cycles after CS rises.
- Joystick frame: 02 A5 -> JOY=8'hA5, FRAME_OK=1 for one cycle, matrix unchanged.
- Errors, each of which must give FRAME_ERR once with JOY and matrix unchanged:
  - command 02 with only 7 data bits
  - command 02 with 16 data bits
  - command 55 followed by 8 bits
  - CS rise after 4 bits
- Multi-row select: row 0 bit 0 pressed and row 7 bit 4 pressed, A_HI=8'h7E -> KBD_ROWS=5'b01110.
- Reset mid-frame: assert CPU_RESET after 20 bits of a matrix frame, then release it with CS still low and finish the clocks. No pulse, KBD_ROWS=5'b11111. The next complete frame commits normally.
